// File: rtl/mc_control_unit_if.sv
// Control bus between the multi-cycle MIPS control unit and the datapath.
// master = control unit, slave = datapath / instruction register / memory.
interface mc_control_unit_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3,
  parameter int CNT_W  = 32
);
  logic [OPW-1:0]    opcode;
  logic              zero;
  logic              mem_ready;
  logic              pcwrite;
  logic              pcwritecond;
  logic              iord;
  logic              irwrite;
  logic              er;
  logic              ew;
  logic              regdst;
  logic              memtoreg;
  logic              regwrite;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [ALUOPW-1:0] aluop;
  logic [1:0]        pcsrc;
  logic              illegal;
  logic              instr_done;
  logic [CNT_W-1:0]  retired;
  logic [3:0]        state;

  modport master (
    input  opcode, zero, mem_ready,
    output pcwrite, pcwritecond, iord, irwrite,
    output er, ew, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, aluop, pcsrc,
    output illegal, instr_done, retired, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pcwrite, pcwritecond, iord, irwrite,
    input  er, ew, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, aluop, pcsrc,
    input  illegal, instr_done, retired, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, with a retired-instruction counter.
module mc_control_unit #(
  parameter int             OPW      = 6,
  parameter int             ALUOPW   = 3,
  parameter int             CNT_W    = 32,
  parameter logic [OPW-1:0] OP_RTYPE = 6'h00,
  parameter logic [OPW-1:0] OP_LW    = 6'h23,
  parameter logic [OPW-1:0] OP_SW    = 6'h2B,
  parameter logic [OPW-1:0] OP_ADDI  = 6'h08,
  parameter logic [OPW-1:0] OP_BEQ   = 6'h04,
  parameter logic [OPW-1:0] OP_J     = 6'h02
) (
  input  logic clk,
  input  logic rst_n,
  mc_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(0);
  localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(1);
  localparam logic [ALUOPW-1:0] ALU_FN  = ALUOPW'(2);

  state_t            state_q;
  state_t            nxt;
  logic [CNT_W-1:0]  retired_q;
  logic              done;
  logic              ill;
  logic              pcwrite;
  logic              pcwritecond;
  logic              iord;
  logic              irwrite;
  logic              er;
  logic              ew;
  logic              regdst;
  logic              memtoreg;
  logic              regwrite;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [ALUOPW-1:0] aluop;
  logic [1:0]        pcsrc;

  logic [OPW-1:0] op;
  logic           is_mem;
  logic           is_r;
  logic           is_beq;
  logic           is_j;
  logic           is_addi;

  assign op      = bus.opcode;
  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_r    = (op == OP_RTYPE);
  assign is_beq  = (op == OP_BEQ);
  assign is_j    = (op == OP_J);
  assign is_addi = (op == OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= nxt;
  end

  always_comb begin
    nxt         = S_FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    er          = 1'b0;
    ew          = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = ALU_ADD;
    pcsrc       = 2'b00;
    ill         = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        er      = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
        nxt     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          is_mem:  nxt = S_MEMADR;
          is_r:    nxt = S_EXEC;
          is_beq:  nxt = S_BRANCH;
          is_j:    nxt = S_JUMP;
          is_addi: nxt = S_ADDIEX;
          default: begin
            nxt = S_FETCH;
            ill = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        er   = 1'b1;
        iord = 1'b1;
        nxt  = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        done     = 1'b1;
      end
      S_MEMWR: begin
        ew   = 1'b1;
        iord = 1'b1;
        done = bus.mem_ready;
        nxt  = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_FN;
        nxt     = S_RWB;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        done     = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALU_SUB;
        pcwritecond = 1'b1;
        pcsrc       = 2'b01;
        done        = 1'b1;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        done    = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        done     = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    retired_q <= '0;
    else if (done) retired_q <= retired_q + 1'b1;
  end

  assign bus.pcwrite     = pcwrite;
  assign bus.pcwritecond = pcwritecond;
  assign bus.iord        = iord;
  assign bus.irwrite     = irwrite;
  assign bus.er          = er;
  assign bus.ew          = ew;
  assign bus.regdst      = regdst;
  assign bus.memtoreg    = memtoreg;
  assign bus.regwrite    = regwrite;
  assign bus.alusrca     = alusrca;
  assign bus.alusrcb     = alusrcb;
  assign bus.aluop       = aluop;
  assign bus.pcsrc       = pcsrc;
  assign bus.illegal     = ill;
  assign bus.instr_done  = done;
  assign bus.retired     = retired_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected state and
// controls are queued by the driver and compared at the falling edge.
module tb_mc_control_unit;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BAD  = 6'h3F;

  localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3;
  localparam int MEMRD = 4, MEMWB = 5, MEMWR = 6, EXEC = 7;
  localparam int RWB = 8, BRANCH = 9, JUMP = 10;
  localparam int ADDIEX = 11, ADDIWB = 12;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        dn;
    logic        il;
    logic [3:0]  ret;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [3:0] mret;
  exp_t sb[$];

  mc_control_unit_if #(.OPW(6), .ALUOPW(3), .CNT_W(4)) bus ();

  mc_control_unit #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] ctl_obs;
  assign ctl_obs = {bus.pcwrite, bus.pcwritecond, bus.iord,
                    bus.irwrite, bus.er, bus.ew, bus.regdst,
                    bus.memtoreg, bus.regwrite, bus.alusrca,
                    bus.alusrcb, bus.aluop, bus.pcsrc};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [16:0] exp_ctl(input int st, input bit mr);
    logic pw, pwc, io, irw, r, w, rd, m2r, rw, sa;
    logic [1:0] sbv, ps;
    logic [2:0] op;
    {pw, pwc, io, irw, r, w, rd, m2r, rw, sa} = '0;
    sbv = 2'b00;
    ps  = 2'b00;
    op  = 3'd0;
    case (st)
      FETCH:  begin r = 1; sbv = 2'b01; pw = mr; irw = mr; end
      DECODE: sbv = 2'b11;
      MEMADR: begin sa = 1; sbv = 2'b10; end
      MEMRD:  begin r = 1; io = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin w = 1; io = 1; end
      EXEC:   begin sa = 1; op = 3'd2; end
      RWB:    begin rw = 1; rd = 1; end
      BRANCH: begin sa = 1; op = 3'd1; pwc = 1; ps = 2'b01; end
      JUMP:   begin pw = 1; ps = 2'b10; end
      ADDIEX: begin sa = 1; sbv = 2'b10; end
      ADDIWB: rw = 1;
      default: ;
    endcase
    return {pw, pwc, io, irw, r, w, rd, m2r, rw, sa, sbv, op, ps};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("state", bus.state, e.st);
      chk("ctl", ctl_obs, e.ctl);
      chk("instr_done", bus.instr_done, e.dn);
      chk("illegal", bus.illegal, e.il);
      chk("retired", bus.retired, e.ret);
      chk("er_ew_excl", bus.er & bus.ew, 0);
    end
  end

  task automatic step(input int st, input bit mr, input bit dn,
                      input bit il);
    exp_t e;
    bus.mem_ready = mr;
    e.st  = st[3:0];
    e.ctl = exp_ctl(st, mr);
    e.dn  = dn;
    e.il  = il;
    e.ret = mret;
    sb.push_back(e);
    if (dn) mret = mret + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input int wf, input int wm);
    bus.opcode = op;
    repeat (wf) step(FETCH, 0, 0, 0);
    step(FETCH, 1, 0, 0);
    case (op)
      OP_R: begin
        step(DECODE, 1, 0, 0);
        step(EXEC, 1, 0, 0);
        step(RWB, 1, 1, 0);
      end
      OP_LW: begin
        step(DECODE, 1, 0, 0);
        step(MEMADR, 1, 0, 0);
        repeat (wm) step(MEMRD, 0, 0, 0);
        step(MEMRD, 1, 0, 0);
        step(MEMWB, 1, 1, 0);
      end
      OP_SW: begin
        step(DECODE, 1, 0, 0);
        step(MEMADR, 1, 0, 0);
        repeat (wm) step(MEMWR, 0, 0, 0);
        step(MEMWR, 1, 1, 0);
      end
      OP_BEQ: begin
        step(DECODE, 1, 0, 0);
        step(BRANCH, 1, 1, 0);
      end
      OP_J: begin
        step(DECODE, 1, 0, 0);
        step(JUMP, 1, 1, 0);
      end
      OP_ADDI: begin
        step(DECODE, 1, 0, 0);
        step(ADDIEX, 1, 0, 0);
        step(ADDIWB, 1, 1, 0);
      end
      default: step(DECODE, 1, 0, 1);
    endcase
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    mret  = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(IDLE, 1, 0, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mret   = 4'd0;
    rst_n  = 1'b0;
    bus.opcode    = OP_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_ctl", ctl_obs, 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_done", bus.instr_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(IDLE, 1, 0, 0);
    instr(OP_R, 0, 0);
    instr(OP_LW, 0, 2);
    instr(OP_SW, 0, 0);
    bus.zero = 1'b1;
    instr(OP_BEQ, 0, 0);
    instr(OP_J, 0, 0);
    instr(OP_BAD, 0, 0);
    bus.zero = 1'b0;
    instr(OP_BEQ, 2, 0);
    instr(OP_SW, 1, 1);
    instr(OP_ADDI, 0, 0);

    reset_cycle();
    repeat (16) instr(OP_ADDI, 0, 0);
    chk("wrap_retired", bus.retired, 0);
    chk("wrap_state", bus.state, FETCH);

    bus.opcode = OP_SW;
    step(FETCH, 1, 0, 0);
    step(DECODE, 1, 0, 0);
    step(MEMADR, 1, 0, 0);
    bus.mem_ready = 1'b0;
    #2;
    chk("pre_rst_ew", bus.ew, 1);
    rst_n = 1'b0;
    #1;
    chk("async_state", bus.state, 0);
    chk("async_ctl", ctl_obs, 0);
    chk("async_ew", bus.ew, 0);
    chk("async_done", bus.instr_done, 0);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("hold_state", bus.state, 0);
    chk("hold_retired", bus.retired, 0);
    @(posedge clk);
    #1;
    mret  = 4'd0;
    rst_n = 1'b1;
    step(IDLE, 1, 0, 0);
    instr(OP_R, 0, 0);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
